// File: rtl/irrigation_zone_controller_if.sv
// Sensor, request, timer-limit and actuator bundle for irrigation_zone_controller.
// master drives sensors/requests/limits; slave drives valves, pump and status.
interface irrigation_zone_controller_if #(
   parameter int ZONES   = 4,
   parameter int TIMER_W = 16
);
   logic [ZONES-1:0]   zone_request;
   logic               tank_low;
   logic               tank_full;
   logic [TIMER_W-1:0] max_water_time;
   logic [TIMER_W-1:0] fill_limit;
   logic [ZONES-1:0]   valve;
   logic               filling;
   logic               zone_timeout;
   logic               fault;

   modport master (
      output zone_request, tank_low, tank_full, max_water_time, fill_limit,
      input  valve, filling, zone_timeout, fault
   );

   modport slave (
      input  zone_request, tank_low, tank_full, max_water_time, fill_limit,
      output valve, filling, zone_timeout, fault
   );
endinterface

// File: rtl/irrigation_zone_controller.sv
// Round-robin irrigation zone controller with tank refill priority.
// Define IRRIGATION_FILL_WATCHDOG_EN to add the fill watchdog and latched FAULT state.
module irrigation_zone_controller #(
   parameter int ZONES   = 4,
   parameter int TIMER_W = 16
) (
   input logic                         clock,
   input logic                         reset,
   irrigation_zone_controller_if.slave bus
);
   localparam int IDX_W = $clog2(ZONES);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WATERING = 2'd1;
   localparam logic [1:0] FILLING  = 2'd2;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
   localparam logic [1:0] FAULT    = 2'd3;
`endif

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               pulse_q, pulse_d;
   logic               eff_low;
   logic               rr_found;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W:0]     rr_k;

`ifdef IRRIGATION_FILL_WATCHDOG_EN
   logic [TIMER_W-1:0] fill_q, fill_d;
`else
   logic fill_limit_unused;
   assign fill_limit_unused = ^bus.fill_limit;
`endif

   // Both sensors high reads as full.
   assign eff_low = bus.tank_low & ~bus.tank_full;

   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_k     = '0;
      for (int i = 1; i <= ZONES; i++) begin
         rr_k = {1'b0, last_q} + (IDX_W+1)'(i);
         if (rr_k >= (IDX_W+1)'(ZONES))
            rr_k = rr_k - (IDX_W+1)'(ZONES);
         if (!rr_found && bus.zone_request[rr_k[IDX_W-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = rr_k[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      timer_d = timer_q;
      pulse_d = 1'b0;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
      fill_d  = fill_q;
`endif
      case (state_q)
         IDLE: begin
            if (eff_low) begin
               state_d = FILLING;
            end else if (rr_found) begin
               state_d = WATERING;
               grant_d = rr_idx;
               timer_d = bus.max_water_time;
            end
         end
         WATERING: begin
            // A zero timer means the grant has no time limit.
            if (eff_low) begin
               state_d = FILLING;
               last_d  = grant_q;
            end else if (!bus.zone_request[grant_q]) begin
               state_d = IDLE;
               last_d  = grant_q;
            end else if (timer_q == TIMER_W'(1)) begin
               state_d = IDLE;
               last_d  = grant_q;
               pulse_d = 1'b1;
            end else if (timer_q != '0) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         FILLING: begin
            if (bus.tank_full) begin
               state_d = IDLE;
            end
`ifdef IRRIGATION_FILL_WATCHDOG_EN
            else if (bus.fill_limit != '0 &&
                     ({1'b0, fill_q} + 1'b1) >= {1'b0, bus.fill_limit}) begin
               state_d = FAULT;
            end else begin
               fill_d = fill_q + TIMER_W'(1);
            end
`endif
         end
         default: begin
            state_d = state_q;
         end
      endcase
`ifdef IRRIGATION_FILL_WATCHDOG_EN
      if (state_d == FILLING && state_q != FILLING)
         fill_d = '0;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(ZONES-1);
         timer_q <= '0;
         pulse_q <= 1'b0;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
         fill_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
         fill_q  <= fill_d;
`endif
      end
   end

   assign bus.valve        = (state_q == WATERING) ? (ZONES'(1) << grant_q) : '0;
   assign bus.filling      = (state_q == FILLING);
   assign bus.zone_timeout = pulse_q;
`ifdef IRRIGATION_FILL_WATCHDOG_EN
   assign bus.fault        = (state_q == FAULT);
`else
   assign bus.fault        = 1'b0;
`endif
endmodule
